// File: rtl/branch_target_calculator_if.sv
// Operand/result bundle between instruction fetch and the branch target calculator.
// The fetch-side master drives the operands and the calculator (slave) returns the registered target.
interface branch_target_calculator_if #(
    parameter int IMM_W = 16,
    parameter int PC_W  = 8
);
    // Handshake: a result is produced for every cycle where valid_in is high at the
    // rising edge, one cycle later with valid_out high. There is no ready/backpressure.
    logic [IMM_W-1:0] immediate;
    logic [PC_W-1:0]  program_counter;
    logic             valid_in;
    logic [PC_W-1:0]  BT;
    logic             valid_out;
    logic             backward;
    logic             range_err;

    modport master (
        output immediate,
        output program_counter,
        output valid_in,
        input  BT,
        input  valid_out,
        input  backward,
        input  range_err
    );

    modport slave (
        input  immediate,
        input  program_counter,
        input  valid_in,
        output BT,
        output valid_out,
        output backward,
        output range_err
    );
endinterface

// File: rtl/branch_target_calculator.sv
// Branch target = PC + sign-extended (optionally scaled) immediate, truncated to PC width.
// One-cycle registered result with valid strobe, backward-branch and out-of-range flags.
module branch_target_calculator #(
    parameter int IMM_W     = 16,
    parameter int PC_W      = 8,
    parameter int IMM_SHIFT = 0
) (
    input logic                       clk,
    input logic                       reset,
    branch_target_calculator_if.slave bus
);
    localparam int EXT_W = IMM_W + IMM_SHIFT + 2;
    // Sum width also has room for PC_W plus a sign bit, so the add can never overflow.
    localparam int SUM_W = (EXT_W > PC_W + 1) ? EXT_W : PC_W + 2;

    logic [SUM_W-1:0] imm_sx;
    logic [SUM_W-1:0] imm_ext;
    logic [SUM_W-1:0] pc_ext;
    logic [SUM_W-1:0] full_sum;

    logic [PC_W-1:0]  bt_q;
    logic [PC_W-1:0]  bt_d;
    logic             valid_q;
    logic             valid_d;
    logic             backward_q;
    logic             backward_d;
    logic             range_err_q;
    logic             range_err_d;

    always_comb begin
        imm_sx   = {{(SUM_W - IMM_W){bus.immediate[IMM_W-1]}}, bus.immediate};
        imm_ext  = imm_sx << IMM_SHIFT;
        pc_ext   = {{(SUM_W - PC_W){1'b0}}, bus.program_counter};
        full_sum = pc_ext + imm_ext;
    end

    always_comb begin
        bt_d        = bt_q;
        backward_d  = backward_q;
        range_err_d = range_err_q;
        valid_d     = bus.valid_in;
        if (bus.valid_in) begin
            bt_d        = full_sum[PC_W-1:0];
            backward_d  = bus.immediate[IMM_W-1];
            // Any set bit above the PC field (including the sign) means the target is outside [0, 2^PC_W-1].
            range_err_d = |full_sum[SUM_W-1:PC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bt_q        <= '0;
            valid_q     <= 1'b0;
            backward_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            bt_q        <= bt_d;
            valid_q     <= valid_d;
            backward_q  <= backward_d;
            range_err_q <= range_err_d;
        end
    end

    assign bus.BT        = bt_q;
    assign bus.valid_out = valid_q;
    assign bus.backward  = backward_q;
    assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_branch_target_calculator.sv
// Self-checking bench for branch_target_calculator: fixed vector table, corner sequences,
// random back-to-back traffic, all checked through an expected-result queue.
module tb_branch_target_calculator;
    localparam int IMM_W     = 16;
    localparam int PC_W      = 8;
    localparam int IMM_SHIFT = 0;
    localparam int EW        = PC_W + 2;

    logic clk;
    logic reset;

    branch_target_calculator_if #(.IMM_W(IMM_W), .PC_W(PC_W)) bus ();

    branch_target_calculator #(
        .IMM_W(IMM_W),
        .PC_W(PC_W),
        .IMM_SHIFT(IMM_SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic [IMM_W-1:0] imm;
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  bt;
        logic             bwd;
        logic             err;
    } vec_t;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    int checks;
    int errors;
    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [IMM_W-1:0] imm, input logic [PC_W-1:0] pc);
        int full;
        logic [PC_W-1:0] bt;
        logic err;
        full = (int'($signed(imm)) * (1 << IMM_SHIFT)) + int'(pc);
        bt   = full[PC_W-1:0];
        err  = (full < 0) || (full > (1 << PC_W) - 1);
        return {bt, imm[IMM_W-1], err};
    endfunction

    task automatic drive(input logic v, input logic [IMM_W-1:0] imm, input logic [PC_W-1:0] pc,
                         input logic [EW-1:0] exp);
        bus.valid_in        = v;
        bus.immediate       = imm;
        bus.program_counter = pc;
        if (v && !reset) exp_q.push_back(exp);
    endtask

    task automatic tick();
        logic [EW-1:0] e;
        @(posedge clk);
        #1;
        if (reset) begin
            chk("reset_bt", 32'(bus.BT), 32'h0);
            chk("reset_valid", 32'(bus.valid_out), 32'h0);
            chk("reset_backward", 32'(bus.backward), 32'h0);
            chk("reset_range_err", 32'(bus.range_err), 32'h0);
            exp_q.delete();
            last_exp = '0;
        end else if (bus.valid_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid_out", 32'(bus.valid_out), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("bt", 32'(bus.BT), 32'(e[EW-1:2]));
                chk("backward", 32'(bus.backward), 32'(e[1]));
                chk("range_err", 32'(bus.range_err), 32'(e[0]));
                last_exp = e;
            end
        end else begin
            chk("missing_valid_out", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            chk("hold_bt", 32'(bus.BT), 32'(last_exp[EW-1:2]));
            chk("hold_backward", 32'(bus.backward), 32'(last_exp[1]));
            chk("hold_range_err", 32'(bus.range_err), 32'(last_exp[0]));
        end
    endtask

    initial begin
        logic [IMM_W-1:0] ri;
        logic [PC_W-1:0]  rp;
        checks   = 0;
        errors   = 0;
        last_exp = '0;

        vecs[0] = '{16'h1234, 8'h80, 8'hB4, 1'b0, 1'b1};
        vecs[1] = '{16'hFFFF, 8'h84, 8'h83, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 8'h88, 8'h87, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 8'h8C, 8'h8C, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 8'h90, 8'h90, 1'b1, 1'b1};
        vecs[5] = '{16'h0010, 8'hF8, 8'h08, 1'b0, 1'b1};
        vecs[6] = '{16'hFFF0, 8'h10, 8'h00, 1'b1, 1'b0};

        // Reset with live operands: outputs must stay cleared.
        reset = 1'b1;
        drive(1'b1, 16'h1234, 8'h80, '0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b1, vecs[0].imm, vecs[0].pc, {vecs[0].bt, vecs[0].bwd, vecs[0].err});
        tick();

        // Fixed vector table, applied back-to-back.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].imm, vecs[i].pc, {vecs[i].bt, vecs[i].bwd, vecs[i].err});
            tick();
        end

        // valid_in low with new operands: previous result must hold.
        drive(1'b1, vecs[1].imm, vecs[1].pc, {vecs[1].bt, vecs[1].bwd, vecs[1].err});
        tick();
        drive(1'b0, 16'h1234, 8'h55, '0);
        tick();
        chk("hold_83", 32'(bus.BT), 32'h83);
        tick();

        // Random traffic with occasional bubbles.
        for (int n = 0; n < 60; n++) begin
            ri = 16'($urandom_range(0, 16'hFFFF));
            rp = 8'($urandom_range(0, 8'hFF));
            if (n % 4 == 0) ri = {{(IMM_W-6){ri[5]}}, ri[5:0]};
            drive(($urandom_range(0, 3) != 0), ri, rp, model(ri, rp));
            tick();
        end

        // Reset while a result is valid and another operation is being issued.
        drive(1'b1, 16'h0005, 8'h20, model(16'h0005, 8'h20));
        tick();
        chk("pre_reset_valid", 32'(bus.valid_out), 32'h1);
        reset = 1'b1;
        drive(1'b1, 16'hFFFE, 8'h40, '0);
        tick();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 8'h00, '0);
        tick();
        chk("post_reset_no_result", 32'(bus.valid_out), 32'h0);
        drive(1'b1, 16'h0003, 8'hFE, model(16'h0003, 8'hFE));
        tick();
        drive(1'b0, 16'h0000, 8'h00, '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
